// File: rtl/sti_rx_if.sv
// sti_rx_if: bundles the configuration, serial-link and parallel-output
// signals of the STI receiver.
//   slave  modport: seen by the receiver (cfg_*/si_* in, po_*/status out)
//   master modport: seen by whatever drives the link and reads the payload
// Parameter CNT_W sets the width of frame_cnt.
interface sti_rx_if #(
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [1:0]       cfg_length;
  logic             cfg_fill;
  logic             cfg_msb;
  logic             cfg_low;
  logic             cfg_ready;
  logic             si_data;
  logic             si_valid;
  logic [15:0]      po_data;
  logic             po_valid;
  logic             po_err;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;
  logic             busy;

  modport slave (
    input  cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low,
    input  si_data, si_valid,
    output cfg_ready, po_data, po_valid, po_err, frame_err, frame_cnt, busy
  );

  modport master (
    output cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low,
    output si_data, si_valid,
    input  cfg_ready, po_data, po_valid, po_err, frame_err, frame_cnt, busy
  );
endinterface

// File: rtl/sti_rx.sv
// sti_rx: serial-to-parallel receiver for the STI link.
// Collects an 8/16/24/32-bit frame one bit per cycle, extracts the 16-bit
// payload according to the latched format and flags nonzero padding bits.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - sti_rx_if.slave: cfg_* capture (cfg_load/cfg_ready), serial
//           input (si_data/si_valid), payload output (po_data/po_valid/
//           po_err) and status (frame_err, frame_cnt, busy)
module sti_rx #(
  parameter int CNT_W = 8
) (
  input  logic   clk,
  input  logic   reset,
  sti_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RECV = 2'd2, DONE = 2'd3} state_t;

  state_t           state_r, state_n;
  logic [1:0]       len_r;
  logic             fill_r, msb_r, low_r;
  logic [4:0]       cnt_r, cnt_n;
  logic [31:0]      frame_r, frame_n;
  logic             latch_cfg_s, frame_err_s, done_s;
  logic [4:0]       frame_last_s;
  logic [4:0]       bit_idx_s;

  logic [15:0]      po_data_r;
  logic             po_valid_r, po_err_r, frame_err_r, cfg_ready_r, busy_r;
  logic [CNT_W-1:0] frame_cnt_r;

  // Payload field selection for the latched format.
  function automatic logic [15:0] extract(input logic [1:0] len, input logic fill,
                                          input logic low, input logic [31:0] f);
    logic [15:0] p;
    case (len)
      2'b00:   p = low ? {f[7:0], 8'h00} : {8'h00, f[7:0]};
      2'b01:   p = f[15:0];
      2'b10:   p = fill ? f[23:8] : f[15:0];
      2'b11:   p = fill ? f[31:16] : f[15:0];
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

  // Any set bit inside the frame but outside the payload field.
  function automatic logic pad_err(input logic [1:0] len, input logic fill,
                                   input logic [31:0] f);
    logic e;
    case (len)
      2'b10:   e = fill ? (|f[7:0]) : (|f[23:16]);
      2'b11:   e = fill ? (|f[15:0]) : (|f[31:16]);
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  // N-1 for the latched length is simply {len,3'b111}.
  assign frame_last_s = {len_r, 3'b111};
  assign bit_idx_s    = msb_r ? (frame_last_s - cnt_r) : cnt_r;

  // Next-state, bit counter and frame assembly.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    frame_n     = frame_r;
    latch_cfg_s = 1'b0;
    frame_err_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n   = 5'd0;
        frame_n = 32'd0;
        if (bus.cfg_load) begin
          latch_cfg_s = 1'b1;
          state_n     = ARMED;
        end else begin
          state_n = IDLE;
        end
      end
      ARMED: begin
        if (bus.si_valid) begin
          frame_n            = 32'd0;
          frame_n[bit_idx_s] = bus.si_data;
          cnt_n              = 5'd1;
          state_n            = RECV;
        end else begin
          state_n = ARMED;
        end
      end
      RECV: begin
        if (bus.si_valid) begin
          frame_n[bit_idx_s] = bus.si_data;
          cnt_n              = cnt_r + 5'd1;
          if (cnt_r == frame_last_s) begin
            // This edge samples the Nth bit.
            done_s  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = RECV;
          end
        end else begin
          frame_err_s = 1'b1;
          cnt_n       = 5'd0;
          frame_n     = 32'd0;
          state_n     = IDLE;
        end
      end
      DONE: begin
        cnt_n   = 5'd0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = 5'd0;
        frame_n = 32'd0;
        state_n = IDLE;
      end
    endcase
  end

  // State, configuration latch and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= 2'b00;
      fill_r      <= 1'b0;
      msb_r       <= 1'b0;
      low_r       <= 1'b0;
      cnt_r       <= 5'd0;
      frame_r     <= 32'd0;
      po_data_r   <= 16'h0000;
      po_valid_r  <= 1'b0;
      po_err_r    <= 1'b0;
      frame_err_r <= 1'b0;
      frame_cnt_r <= {CNT_W{1'b0}};
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      frame_r <= frame_n;
      if (latch_cfg_s) begin
        len_r  <= bus.cfg_length;
        fill_r <= bus.cfg_fill;
        msb_r  <= bus.cfg_msb;
        low_r  <= bus.cfg_low;
      end
      // Payload is built from the frame including the bit sampled this edge.
      if (done_s) begin
        po_data_r <= extract(len_r, fill_r, low_r, frame_n);
        po_err_r  <= pad_err(len_r, fill_r, frame_n);
      end else begin
        po_err_r  <= 1'b0;
      end
      po_valid_r  <= done_s;
      frame_err_r <= frame_err_s;
      // Counter steps on the edge that ends the DONE cycle.
      if (state_r == DONE) begin
        frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      cfg_ready_r <= (state_n == IDLE);
      busy_r      <= (state_n == ARMED) || (state_n == RECV);
    end
  end

  assign bus.po_data   = po_data_r;
  assign bus.po_valid  = po_valid_r;
  assign bus.po_err    = po_err_r;
  assign bus.frame_err = frame_err_r;
  assign bus.frame_cnt = frame_cnt_r;
  assign bus.cfg_ready = cfg_ready_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: directed, table-driven bench for sti_rx (frame counter width 2).
module tb_sti_rx;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  sti_rx_if #(.CNT_W(2)) bus ();
  sti_rx #(.CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string       name;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic [31:0] value;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_po_data"}, {16'h0000, bus.po_data}, 32'h0000_0000);
    chk({tag, "_po_valid"}, {31'd0, bus.po_valid}, 32'd0);
    chk({tag, "_po_err"}, {31'd0, bus.po_err}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_frame_cnt"}, {30'd0, bus.frame_cnt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_cfg_ready"}, {31'd0, bus.cfg_ready}, 32'd1);
  endtask

  task automatic load_cfg(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    bus.cfg_load   = 1'b1;
    bus.cfg_length = len;
    bus.cfg_fill   = fill;
    bus.cfg_msb    = msb;
    bus.cfg_low    = low;
    step();
    bus.cfg_load   = 1'b0;
    // Scramble the live inputs: only the latched copy may matter now.
    bus.cfg_length = ~len;
    bus.cfg_fill   = ~fill;
    bus.cfg_msb    = ~msb;
    bus.cfg_low    = ~low;
  endtask

  // Full frame: load, send N bits (with cfg_load pulses while busy), check
  // the DONE cycle and the following idle cycle.
  task automatic send_frame(input vec_t v);
    int n;
    n = (int'(v.len) + 1) * 8;
    load_cfg(v.len, v.fill, v.msb, v.low);
    chk({v.name, "_armed_busy"}, {31'd0, bus.busy}, 32'd1);
    chk({v.name, "_armed_ready"}, {31'd0, bus.cfg_ready}, 32'd0);
    for (int k = 0; k < n; k++) begin
      bus.si_valid = 1'b1;
      bus.si_data  = v.msb ? v.value[n-1-k] : v.value[k];
      bus.cfg_load = (k == 0) || (k == 2);
      if (k == n - 1) chk({v.name, "_early_valid"}, {31'd0, bus.po_valid}, 32'd0);
      step();
    end
    bus.si_valid = 1'b0;
    bus.si_data  = 1'b0;
    bus.cfg_load = 1'b1;  // ignored in DONE
    chk({v.name, "_po_valid"}, {31'd0, bus.po_valid}, 32'd1);
    chk({v.name, "_po_data"}, {16'h0000, bus.po_data}, {16'h0000, v.exp_data});
    chk({v.name, "_po_err"}, {31'd0, bus.po_err}, {31'd0, v.exp_err});
    chk({v.name, "_cnt_pre"}, {30'd0, bus.frame_cnt}, exp_cnt);
    step();
    bus.cfg_load = 1'b0;
    exp_cnt = (exp_cnt + 1) % 4;
    chk({v.name, "_valid_drop"}, {31'd0, bus.po_valid}, 32'd0);
    chk({v.name, "_ready_after"}, {31'd0, bus.cfg_ready}, 32'd1);
    chk({v.name, "_cnt_post"}, {30'd0, bus.frame_cnt}, exp_cnt);
    step();
    chk({v.name, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"c1_16b_msb",    2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_A5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{"c2_8b_low1",    2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_003C, 16'h3C00, 1'b0};
    vecs[2] = '{"c2_8b_low0",    2'b00, 1'b0, 1'b0, 1'b0, 32'h0000_003C, 16'h003C, 1'b0};
    vecs[3] = '{"c3_32b_ok",     2'b11, 1'b1, 1'b1, 1'b0, 32'hBEEF_0000, 16'hBEEF, 1'b0};
    vecs[4] = '{"c3_32b_pad",    2'b11, 1'b1, 1'b1, 1'b0, 32'hBEEF_0001, 16'hBEEF, 1'b1};
    vecs[5] = '{"32b_fill0_lsb", 2'b11, 1'b0, 1'b0, 1'b0, 32'h0001_BEEF, 16'hBEEF, 1'b1};
    vecs[6] = '{"24b_fill0_msb", 2'b10, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 16'h1234, 1'b0};
    vecs[7] = '{"24b_fill1_pad", 2'b10, 1'b1, 1'b0, 1'b0, 32'h0012_3480, 16'h1234, 1'b1};
    vecs[8] = '{"24b_fill0_pad", 2'b10, 1'b0, 1'b0, 1'b0, 32'h0080_5678, 16'h5678, 1'b1};
    vecs[9] = '{"8b_msb_low0",   2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0096, 16'h0096, 1'b0};

    reset          = 1'b1;
    bus.cfg_load   = 1'b0;
    bus.cfg_length = 2'b00;
    bus.cfg_fill   = 1'b0;
    bus.cfg_msb    = 1'b0;
    bus.cfg_low    = 1'b0;
    bus.si_data    = 1'b0;
    bus.si_valid   = 1'b0;
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;

    // si_valid in IDLE is ignored.
    bus.si_valid = 1'b1;
    bus.si_data  = 1'b1;
    step();
    step();
    chk("idle_ignore_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_ignore_ready", {31'd0, bus.cfg_ready}, 32'd1);
    bus.si_valid = 1'b0;
    bus.si_data  = 1'b0;
    step();

    // Table-driven frames; 10 frames walk the 2-bit counter round twice.
    for (int i = 0; i < 10; i++) send_frame(vecs[i]);

    // Case 4: ARMED waits through idle cycles, then si_valid drops after 10 bits.
    load_cfg(2'b10, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("c4_armed_wait_busy", {31'd0, bus.busy}, 32'd1);
    chk("c4_armed_wait_ferr", {31'd0, bus.frame_err}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      bus.si_valid = 1'b1;
      bus.si_data  = k[0];
      step();
    end
    bus.si_valid = 1'b0;
    step();
    chk("c4_frame_err", {31'd0, bus.frame_err}, 32'd1);
    chk("c4_no_valid", {31'd0, bus.po_valid}, 32'd0);
    chk("c4_po_data_kept", {16'h0000, bus.po_data}, 32'h0000_0096);
    chk("c4_cnt_kept", {30'd0, bus.frame_cnt}, exp_cnt);
    chk("c4_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("c4_busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("c4_frame_err_pulse", {31'd0, bus.frame_err}, 32'd0);
    chk("c4_no_valid_late", {31'd0, bus.po_valid}, 32'd0);

    // Case 5: reset after 5 bits of a 32b frame, then a 24b fill=1 frame.
    load_cfg(2'b11, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.si_valid = 1'b1;
      bus.si_data  = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    chk_reset_state("c5_midframe_reset");
    reset        = 1'b0;
    bus.si_valid = 1'b0;
    exp_cnt      = 0;
    step();
    send_frame('{"c5_24b_fill1", 2'b10, 1'b1, 1'b1, 1'b0, 32'h0012_3400, 16'h1234, 1'b0});

    // Case 6: back-to-back frames; counter continues 2,3,0,1 after the frame above.
    for (int i = 0; i < 4; i++) send_frame(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sti_rx.md
Name: sti_rx

Overview:
Serial-to-parallel receiver for the STI serial stream: the far end of the serial transmitter link.
- Accepts one bit per cycle on si_data while si_valid is high.
- Reassembles an 8/16/24/32-bit frame, using per-frame format fields that match the transmitter's pi_length/pi_fill/pi_msb/pi_low encoding.
- Extracts the 16-bit payload and checks padding bits.
- Sits between the serial link and the downstream parallel consumer (loopback checker / host register file).

Parameters:
CNT_W, 8, width of the received-frame counter frame_cnt (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cfg_load  input  1  one-cycle strobe; captures cfg_* for the next frame when cfg_ready=1
cfg_length  input  2  00=8b, 01=16b, 10=24b, 11=32b frame
cfg_fill  input  1  24/32b: 1=payload in upper bits, 0=payload in low 16 bits
cfg_msb  input  1  1=first serial bit is frame bit N-1; 0=first bit is bit 0
cfg_low  input  1  8b: 1=received byte is payload[15:8], 0=payload[7:0]
cfg_ready  output  1  high in IDLE only
si_data  input  1  serial data bit
si_valid  input  1  bit qualifier; must stay high for all N bits of a frame
po_data  output  16  reconstructed payload; held until next po_valid
po_valid  output  1  one-cycle pulse, frame complete
po_err  output  1  valid with po_valid: a padding bit was nonzero
frame_err  output  1  one-cycle pulse: si_valid dropped mid-frame
frame_cnt  output  CNT_W  count of po_valid pulses, wraps
busy  output  1  high in ARMED or RECV

Behaviour:
Reset (synchronous, highest priority, any state, mid-frame included):
- State is IDLE.
- po_data=0, po_valid=0, po_err=0, frame_err=0, frame_cnt=0, busy=0, cfg_ready=1.
- Bit counter and shift register are cleared.

States:
- IDLE: cfg_ready=1. cfg_load=1 latches the cfg_* fields and moves to ARMED. si_valid is ignored in IDLE.
- ARMED: waits for si_valid=1. The first valid bit is stored, bit count becomes 1, and the state moves to RECV. cfg_load is ignored.
- RECV: each cycle with si_valid=1 stores one bit and increments the count.
  - When the count reaches N (8/16/24/32), the state moves to DONE. The last bit is captured on that same edge.
  - si_valid=0 in RECV: frame_err pulses for 1 cycle, the partial frame is discarded, po_data is unchanged, and the state returns to IDLE.
- DONE: lasts exactly one cycle. po_valid=1, po_err is valid, frame_cnt increments on this cycle's edge. Then IDLE. cfg_load during DONE is ignored.

Latency: po_valid is asserted in the cycle after the edge that samples the Nth bit.

Bit placement (frame register F[31:0], cleared at the start of each frame):
- cfg_msb=1: the k-th received bit (k=0..N-1) goes to F[N-1-k].
- cfg_msb=0: the k-th received bit goes to F[k].

Payload extraction:
- 8b: low=1 gives {F[7:0],8'h00}; low=0 gives {8'h00,F[7:0]}.
- 16b: F[15:0].
- 24b: fill=1 gives F[23:8]; fill=0 gives F[15:0].
- 32b: fill=1 gives F[31:16]; fill=0 gives F[15:0].

Padding check:
- po_err=1 if any bit of F[N-1:0] outside the payload field is 1.
- 8b and 16b frames never set po_err.

cfg_* inputs may change freely after cfg_load is sampled; only the latched copy is used.

Test Plan:
- Case 1: reset; cfg_load with length=01, msb=1; send 16'hA5C3 MSB-first with si_valid high for 16 cycles -> one cycle later po_valid=1 for 1 cycle, po_data=16'hA5C3, po_err=0, frame_cnt=1, cfg_ready=1 the next cycle.
- Case 2: length=00, low=1, msb=0; send byte 8'h3C LSB-first -> po_data=16'h3C00, po_err=0. Repeat with low=0 -> po_data=16'h003C.
- Case 3: length=11, fill=1, msb=1; send 32'hBEEF0000 -> po_data=16'hBEEF, po_err=0. Then send 32'hBEEF0001 -> po_data=16'hBEEF, po_err=1.
- Case 4: length=10, fill=0; drop si_valid after 10 bits -> frame_err pulses 1 cycle, no po_valid, po_data keeps its previous value, frame_cnt unchanged, state returns to IDLE (cfg_ready=1).
- Case 5: reset asserted after 5 bits of a 32b frame -> all outputs at reset values the next cycle. A following 24b fill=1 frame of 24'h12_3400 -> po_data=16'h1234, po_err=0.
- Case 6: CNT_W=2; receive 5 good frames back-to-back -> frame_cnt reads 1,2,3,0,1. cfg_load during RECV/DONE is ignored, so the in-flight frame's format is unchanged.
